video_line_doubler: RTL and testbench

- Parametrised successor to the fixed 4-bit CGA scandoubler: a generic line-buffer scan doubler for the video adapters (CGA/Tandy/MDA).
- Captures one input scanline of PIX_W-bit pixels into a ping-pong line buffer, then replays the previous line twice at double pixel rate with its own sync pulse.
- Measures line length at runtime, so every adapter timing works without retuning.
- Sits between the adapter pixel pipeline and the VGA-rate output mux.

---
 rtl/video_line_doubler.sv | 146 ++++++++++++++
 tb/tb_video_line_doubler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/video_line_doubler.sv
// Line-buffer scan doubler: captures one input line into a ping-pong
// buffer and replays the previous line twice at double pixel rate.
// Ports: clk, reset_l (async low), in_ce/line_reset/video_in (input
// pixel stream), scanlines (second-pass darken), dbl_video/dbl_hsync/
// second_pass (doubled output, 2 clk after out_ce), line_len, overflow.
// Option: VIDEO_LINE_DOUBLER_SCANLINES_EN blanks SECOND-pass pixels
// while scanlines=1; when undefined, scanlines is ignored.
module video_line_doubler #(
  parameter int PIX_W    = 4,
  parameter int MAX_LINE = 1024,
  parameter int IN_DIV   = 2,
  parameter int HSYNC_W  = 64
) (
  input  logic                          clk,
  input  logic                          reset_l,
  input  logic                          in_ce,
  input  logic                          line_reset,
  input  logic [PIX_W-1:0]              video_in,
  input  logic                          scanlines,
  output logic [PIX_W-1:0]              dbl_video,
  output logic                          dbl_hsync,
  output logic                          second_pass,
  output logic [$clog2(MAX_LINE+1)-1:0] line_len,
  output logic                          overflow
);

  localparam int LW   = $clog2(MAX_LINE + 1);
  localparam int AW   = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int HALF = IN_DIV / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [LW-1:0] MAXV = LW'(MAX_LINE);
  localparam logic [31:0]   HSV  = 32'(HSYNC_W);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} pass_t;

  pass_t pass;

  logic [PIX_W-1:0] mem [2][MAX_LINE];
  logic [PIX_W-1:0] rd_data;

  logic          lr_q;
  logic          lr_q2;
  logic          ev;
  logic          wr_bank;
  logic [LW-1:0] wr_addr;
  logic [LW-1:0] rd_addr;
  logic [PW-1:0] phase;
  logic          out_ce;
  logic          wr_sel;
  logic [LW-1:0] wr_idx;
  logic          wr_en;
  logic          wrap;
  logic          hs_now;
  logic          rd_en;
  logic          s1_act;
  logic          s1_hs;
  logic          s1_sec;
  logic          blank;

  assign ev     = lr_q & ~lr_q2;
  assign out_ce = (phase == '0);

  // A pixel arriving with the line event starts the new line.
  assign wr_sel = ev ? ~wr_bank : wr_bank;
  assign wr_idx = ev ? '0 : wr_addr;
  assign wr_en  = in_ce && (wr_idx < MAXV);

  assign wrap   = (rd_addr == line_len - LW'(1));
  assign hs_now = 32'(rd_addr) < HSV;
  assign rd_en  = out_ce && !ev && (pass != IDLE);

`ifdef VIDEO_LINE_DOUBLER_SCANLINES_EN
  assign blank = !s1_act || s1_hs || (scanlines && s1_sec);
`else
  assign blank = !s1_act || s1_hs;
  logic unused_scanlines;
  assign unused_scanlines = scanlines;
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_sel][wr_idx[AW-1:0]] <= video_in;
    if (rd_en)
      rd_data <= mem[~wr_bank][rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lr_q        <= 1'b0;
      lr_q2       <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      phase       <= '0;
      pass        <= IDLE;
      line_len    <= '0;
      overflow    <= 1'b0;
      s1_act      <= 1'b0;
      s1_hs       <= 1'b0;
      s1_sec      <= 1'b0;
      dbl_video   <= '0;
      dbl_hsync   <= 1'b0;
      second_pass <= 1'b0;
    end else begin
      lr_q  <= line_reset;
      lr_q2 <= lr_q;
      if (ev) begin
        line_len <= wr_addr;
        wr_bank  <= ~wr_bank;
        wr_addr  <= in_ce ? LW'(1) : '0;
        rd_addr  <= '0;
        phase    <= '0;
        pass     <= (wr_addr != '0) ? FIRST : IDLE;
        s1_act   <= 1'b0;
      end else begin
        if (in_ce) begin
          if (wr_addr < MAXV)
            wr_addr <= wr_addr + 1'b1;
          else
            overflow <= 1'b1;
        end
        phase <= (phase == PW'(HALF - 1)) ? '0 : phase + 1'b1;
        if (out_ce) begin
          s1_act <= (pass != IDLE);
          s1_hs  <= hs_now;
          s1_sec <= (pass == SECOND);
        end
        if (rd_en) begin
          if (wrap) begin
            rd_addr <= '0;
            unique case (pass)
              FIRST:   pass <= SECOND;
              default: pass <= IDLE;
            endcase
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
      end
      dbl_video   <= blank ? '0 : rd_data;
      dbl_hsync   <= s1_act & s1_hs;
      second_pass <= s1_act & s1_sec;
    end
  end

endmodule

// File: tb/tb_video_line_doubler.sv
// Scoreboard bench for video_line_doubler: a line-level model predicts
// every output clock; a monitor pops and compares each prediction.
module tb_video_line_doubler;

  localparam int PIX_W    = 4;
  localparam int MAX_LINE = 16;
  localparam int IN_DIV   = 2;
  localparam int HSYNC_W  = 4;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       in_ce = 1'b0;
  logic       line_reset = 1'b0;
  logic [3:0] video_in = '0;
  logic       scanlines = 1'b0;
  logic [3:0] dbl_video;
  logic       dbl_hsync;
  logic       second_pass;
  logic [4:0] line_len;
  logic       overflow;

  video_line_doubler #(
    .PIX_W(PIX_W), .MAX_LINE(MAX_LINE),
    .IN_DIV(IN_DIV), .HSYNC_W(HSYNC_W)
  ) dut (
    .clk(clk), .reset_l(reset_l), .in_ce(in_ce),
    .line_reset(line_reset), .video_in(video_in),
    .scanlines(scanlines), .dbl_video(dbl_video),
    .dbl_hsync(dbl_hsync), .second_pass(second_pass),
    .line_len(line_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         care;
    logic [3:0] v;
    logic       hs;
    logic       sec;
    logic [4:0] ll;
    logic       ovf;
    int         ed;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // line model state
  logic       lr_h1 = 0;
  logic       lr_h2 = 0;
  logic [3:0] cur[$];
  logic [3:0] rp[$];
  int         rp_len = 0;
  int         rp_start = 0;
  bit         rp_care = 0;
  int         nev = 0;
  int         ml_len = 0;
  logic       m_ovf = 0;
  int         edge_n = 0;
  bit         sl = 0;

  task automatic check(input string nm, input int got,
                       input int expv, input int ed);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h",
               nm, ed, got, expv);
    end
  endtask

  // One clock of stimulus plus the prediction for the output that
  // becomes visible after the upcoming rising edge.
  task automatic step(input logic lr, input logic ce,
                      input logic [3:0] px);
    exp_t e;
    int   j;
    int   idx;
    bit   evt;
    @(negedge clk);
    line_reset = lr;
    in_ce      = ce;
    video_in   = px;
    e.care = 1; e.v = 0; e.hs = 0; e.sec = 0;
    j = edge_n - rp_start;
    if (rp_len > 0 && j >= 0 && j < 2 * rp_len) begin
      idx    = j % rp_len;
      e.sec  = (j >= rp_len);
      e.hs   = (idx < HSYNC_W);
      e.v    = e.hs ? 4'd0 : rp[idx];
`ifdef VIDEO_LINE_DOUBLER_SCANLINES_EN
      if (sl && e.sec) e.v = 4'd0;
`endif
      e.care = rp_care;
    end
    evt = lr_h1 && !lr_h2;
    if (evt) begin
      nev++;
      ml_len = cur.size();
      rp_len = cur.size();
      if (rp_len > 0) begin
        rp       = cur;
        rp_start = edge_n + 2;
        rp_care  = (nev >= 2);
      end
      cur.delete();
    end
    if (ce) begin
      if (cur.size() < MAX_LINE) cur.push_back(px);
      else m_ovf = 1;
    end
    e.ll  = 5'(ml_len);
    e.ovf = m_ovf;
    e.ed  = edge_n;
    q.push_back(e);
    lr_h2 = lr_h1;
    lr_h1 = lr;
    edge_n++;
  endtask

  task automatic send_line(input int n, input bit align,
                           input int gap, input bit pat);
    int         total;
    int         k;
    logic       ce;
    logic [3:0] px;
    total = 2 * n + 1 + gap;
    if (total < 3) total = 3;
    k = 0;
    for (int s = 0; s < total; s++) begin
      if (align) ce = (s % 2 == 1) && (s < 2 * n);
      else       ce = (s % 2 == 0) && (s > 0) && (s <= 2 * n);
      px = pat ? 4'(k % 16) : 4'($urandom);
      if (!ce) px = 4'($urandom);
      step(s < 2, ce, px);
      if (ce) k++;
    end
  endtask

  task automatic do_reset(input bit new_sl);
    @(negedge clk);
    reset_l    = 0;
    line_reset = 0;
    in_ce      = 0;
    #1;
    check("rst_video", int'(dbl_video), 0, -1);
    check("rst_hsync", int'(dbl_hsync), 0, -1);
    check("rst_second", int'(second_pass), 0, -1);
    check("rst_line_len", int'(line_len), 0, -1);
    check("rst_overflow", int'(overflow), 0, -1);
    q.delete();
    repeat (2) @(negedge clk);
    lr_h1 = 0; lr_h2 = 0;
    cur.delete();
    rp_len = 0; nev = 0; ml_len = 0; m_ovf = 0;
    sl = new_sl;
    scanlines = new_sl;
    reset_l = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_l && q.size() > 0) begin
        e = q.pop_front();
        check("line_len", int'(line_len), int'(e.ll), e.ed);
        check("overflow", int'(overflow), int'(e.ovf), e.ed);
        if (e.care) begin
          check("dbl_video", int'(dbl_video), int'(e.v), e.ed);
          check("dbl_hsync", int'(dbl_hsync), int'(e.hs), e.ed);
          check("second_pass", int'(second_pass), int'(e.sec), e.ed);
        end
      end
    end
  end

  initial begin : stim
    do_reset(0);
    repeat (3) step(0, 0, 0);
    // nominal 10-pixel lines, pattern n mod 16
    repeat (4) send_line(10, 1, 0, 1);
    // early line aborting the replay of a 10-pixel line
    send_line(6, 1, 0, 1);
    send_line(10, 0, 3, 1);
    // overflow: 20 pixels into a 16-deep bank
    send_line(20, 1, 2, 1);
    send_line(8, 1, 4, 0);
    send_line(8, 0, 4, 0);
    // reset while the FIRST pass is running
    send_line(10, 1, 0, 1);
    step(1, 0, 4'h3);
    step(1, 1, 4'hA);
    step(0, 0, 4'h0);
    step(0, 1, 4'h5);
    step(0, 0, 4'h0);
    do_reset(1);
    repeat (3) step(0, 0, 0);
    repeat (3) send_line(10, 1, 1, 1);
    // random lines: lengths incl. 0, sub-hsync and overflowing
    for (int i = 0; i < 40; i++)
      send_line($urandom_range(0, 18), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), 0);
    send_line(5, 1, 0, 0);
    repeat (40) step(0, 0, 0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
